// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider (ratio 2..2^CNT_W-1) with glitch-free ratio changes
// and clean start/stop. Define ODD_DUTY50_EN for a 50% duty cycle at odd ratios (adds a negedge flop).
module clk_div_prog #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_in,
  input  logic             arst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_div_load,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_running,
  output logic [CNT_W-1:0] o_div_active
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_active;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_running;

  logic             w_at_end;
  logic             w_adv;
  logic             w_wrap;
  logic             w_idle_load;
  logic             w_swap;
  logic             w_pend_eff;
  logic [CNT_W-1:0] w_div_clamped;
  logic [CNT_W-1:0] w_shadow_eff;
  logic [CNT_W-1:0] w_n_nxt;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_at_end      = (r_cnt == (r_div_active - ONE));
  assign w_adv         = ~w_at_end | i_en;
  assign w_wrap        = w_at_end & i_en;
  assign w_idle_load   = w_at_end & ~i_en & r_pend;
  assign w_div_clamped = (i_div < TWO) ? TWO : i_div;

  // A load landing on the wrap edge takes effect at that same wrap.
  assign w_shadow_eff  = i_div_load ? w_div_clamped : r_shadow;
  assign w_pend_eff    = i_div_load | r_pend;
  assign w_swap        = w_wrap & w_pend_eff;

  always_comb begin
    w_n_nxt = r_div_active;
    if (w_swap)
      w_n_nxt = w_shadow_eff;
    else if (w_idle_load)
      w_n_nxt = r_shadow;
  end

  assign w_h_nxt = w_n_nxt >> 1;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_idle_load)
      w_cnt_nxt = r_shadow - ONE;
    else if (w_wrap)
      w_cnt_nxt = '0;
    else if (w_adv)
      w_cnt_nxt = r_cnt + ONE;
  end

  always_ff @(posedge clk_in or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt        <= DEF_N - ONE;
      r_div_active <= DEF_N;
      r_shadow     <= DEF_N;
      r_pend       <= 1'b0;
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_div_active <= w_n_nxt;
      r_clk_out    <= w_adv & (w_cnt_nxt < w_h_nxt);
      r_tick       <= w_adv & (w_cnt_nxt == '0);
      r_running    <= w_adv | i_en;
      if (i_div_load)
        r_shadow <= w_div_clamped;
      if (w_swap)
        r_pend <= 1'b0;
      else if (i_div_load)
        r_pend <= 1'b1;
      else if (w_idle_load)
        r_pend <= 1'b0;
    end
  end

`ifdef ODD_DUTY50_EN
  // Half-cycle stretch of the high phase for odd ratios; output must be a generated clock.
  logic r_hold_n;

  always_ff @(negedge clk_in or negedge arst_n) begin
    if (!arst_n)
      r_hold_n <= 1'b0;
    else
      r_hold_n <= r_clk_out & r_div_active[0];
  end

  assign o_clk_out = r_clk_out | r_hold_n;
`else
  assign o_clk_out = r_clk_out;
`endif

  assign o_tick       = r_tick;
  assign o_running    = r_running;
  assign o_div_active = r_div_active;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: vector table for ratio/load/stop sequences,
// hand-written sequences for clamping, the 255 ratio and mid-period reset.
module tb_clk_div_prog;

  logic       clk_in = 1'b0;
  logic       arst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div = 8'd0;
  logic       div_load = 1'b0;
  logic       clk_out;
  logic       tick;
  logic       running;
  logic [7:0] div_active;

  int total = 0;
  int bad   = 0;

  clk_div_prog #(.CNT_W(8), .DEF_DIV(2)) dut (
    .clk_in      (clk_in),
    .arst_n      (arst_n),
    .i_en        (en),
    .i_div       (div),
    .i_div_load  (div_load),
    .o_clk_out   (clk_out),
    .o_tick      (tick),
    .o_running   (running),
    .o_div_active(div_active)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       en;
    logic [7:0] div;
    logic       ld;
    logic       clk;
    logic       tick;
    logic       run;
    logic [7:0] da;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic e, input logic [7:0] d, input logic l,
                              input logic c, input logic t, input logic r, input logic [7:0] a);
    vec_t v;
    v.en = e; v.div = d; v.ld = l; v.clk = c; v.tick = t; v.run = r; v.da = a;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic e, input logic [7:0] d, input logic l);
    en = e; div = d; div_load = l;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    int period;
    int high;

    // N=2 from reset
    add(1,0,0, 1,1,1,2); add(1,0,0, 0,0,1,2); add(1,0,0, 1,1,1,2); add(1,0,0, 0,0,1,2);
    // load 5 on the wrap edge (bypass), then 2 high / 3 low
    add(1,5,1, 1,1,1,5); add(1,0,0, 1,0,1,5); add(1,0,0, 0,0,1,5); add(1,0,0, 0,0,1,5);
    add(1,0,0, 0,0,1,5); add(1,0,0, 1,1,1,5); add(1,0,0, 1,0,1,5);
    // load 4 mid-period of N=5
    add(1,4,1, 0,0,1,5); add(1,0,0, 0,0,1,5); add(1,0,0, 0,0,1,5);
    add(1,0,0, 1,1,1,4); add(1,0,0, 1,0,1,4);
    // load 8 mid-period of N=4, changes exactly at wrap
    add(1,8,1, 0,0,1,4); add(1,0,0, 0,0,1,4); add(1,0,0, 1,1,1,8);
    // loads 3 then 6 during N=8: only 6 is used
    add(1,3,1, 1,0,1,8); add(1,6,1, 1,0,1,8); add(1,0,0, 1,0,1,8);
    add(1,0,0, 0,0,1,8); add(1,0,0, 0,0,1,8); add(1,0,0, 0,0,1,8); add(1,0,0, 0,0,1,8);
    add(1,0,0, 1,1,1,6); add(1,0,0, 1,0,1,6); add(1,0,0, 1,0,1,6);
    add(1,0,0, 0,0,1,6); add(1,0,0, 0,0,1,6); add(1,0,0, 0,0,1,6);
    // rising edge, then en dropped: period completes, idle, restart
    add(1,0,0, 1,1,1,6); add(0,0,0, 1,0,1,6); add(0,0,0, 1,0,1,6);
    add(0,0,0, 0,0,1,6); add(0,0,0, 0,0,1,6); add(0,0,0, 0,0,1,6);
    add(0,0,0, 0,0,0,6); add(0,0,0, 0,0,0,6);
    add(1,0,0, 1,1,1,6); add(1,0,0, 1,0,1,6);

    #12;
    chk("reset_state", {clk_out, tick, running, div_active}, {1'b0, 1'b0, 1'b0, 8'd2});
    arst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].div, vecs[i].ld);
      chk($sformatf("vec%0d", i), {clk_out, tick, running, div_active},
          {vecs[i].clk, vecs[i].tick, vecs[i].run, vecs[i].da});
    end

    // stop from cnt=1 of N=6: four more advancing edges, then idle
    for (n = 0; n < 20; n++) begin
      step(0, 0, 0);
      if (!running) break;
    end
    chk("stop_len", n, 4);
    chk("stop_idle", {clk_out, tick, running}, 3'b000);

    // clamping, applied while idle
    step(0, 8'd0, 1); step(0, 0, 0);
    chk("clamp_div0", div_active, 8'd2);
    step(0, 8'd1, 1); step(0, 0, 0);
    chk("clamp_div1", div_active, 8'd2);
    step(0, 8'd255, 1); step(0, 0, 0);
    chk("idle_load255", {clk_out, running, div_active}, {1'b0, 1'b0, 8'd255});

    step(1, 0, 0);
    chk("start255", {clk_out, tick}, 2'b11);
    period = 0;
    high   = 1;
    for (int k = 1; k <= 300; k++) begin
      step(1, 0, 0);
      if (tick) begin
        period = k;
        break;
      end
      if (clk_out) high++;
    end
    chk("period255", period, 255);
    chk("high255", high, 127);

    // async reset in the high phase
    chk("pre_reset_high", clk_out, 1'b1);
    #2 arst_n = 1'b0;
    #1;
    chk("mid_reset", {clk_out, tick, running, div_active}, {1'b0, 1'b0, 1'b0, 8'd2});
    #1 arst_n = 1'b1;
    step(1, 0, 0);
    chk("restart0", {clk_out, tick, running, div_active}, {1'b1, 1'b1, 1'b1, 8'd2});
    step(1, 0, 0);
    chk("restart1", {clk_out, tick, running}, 3'b001);
    step(1, 0, 0);
    chk("restart2", {clk_out, tick, running}, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
